// File: rtl/neuron_accumulator.sv
// neuron_accumulator: weighted-sum stage of the single-layer perceptron.
// Streams (input, weight) pairs in signed WIDTH-bit fixed point with FRAC fractional bits.
// Each pair is multiplied through one registered product stage. The products are added onto
// a bias that is sampled on the first beat of the frame. One saturated sum is emitted per frame.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (high in IDLE/ACCUM, low during rst)
//   in_data    signed neuron input
//   in_weight  signed weight
//   in_last    final beat of the frame
//   bias       signed bias, sampled on the first beat of the frame
//   sum_valid  sum available
//   sum_ready  downstream accepts the sum
//   sum        signed saturated weighted sum
//   sum_sat    some product or add in this frame clamped
module neuron_accumulator #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_weight,
  input  logic             in_last,
  input  logic [WIDTH-1:0] bias,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [WIDTH-1:0] sum,
  output logic             sum_sat
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] prod;
  logic             prod_valid;
  logic             prod_sat;
  logic             sat_flag;

  logic                    accept;
  logic signed [2*WIDTH-1:0] full;
  logic signed [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]          hi;
  logic                    mul_clamp;
  logic [WIDTH-1:0]        mul_sat;
  logic [WIDTH:0]          add_full;
  logic                    add_clamp;
  logic [WIDTH-1:0]        add_sat;
  logic [WIDTH-1:0]        acc_next;
  logic                    flag_next;

  assign in_ready = ~rst & ((state == IDLE) | (state == ACCUM));
  assign accept   = in_valid & in_ready;

  // Full-width signed product; the arithmetic shift truncates toward -inf.
  assign full    = $signed({{WIDTH{in_data[WIDTH-1]}}, in_data}) *
                   $signed({{WIDTH{in_weight[WIDTH-1]}}, in_weight});
  assign shifted = full >>> FRAC;

  // The shifted product fits only when its top WIDTH+1 bits are all equal.
  always_comb begin
    hi        = shifted[2*WIDTH-1:WIDTH-1];
    mul_clamp = ~((&hi) | ~(|hi));
    mul_sat   = shifted[WIDTH-1:0];
    if (mul_clamp) mul_sat = shifted[2*WIDTH-1] ? MINV : MAXV;
  end

  // WIDTH+1-bit add; overflow shows as disagreement of the top two bits.
  always_comb begin
    add_full  = {acc[WIDTH-1], acc} + {prod[WIDTH-1], prod};
    add_clamp = add_full[WIDTH] ^ add_full[WIDTH-1];
    add_sat   = add_full[WIDTH-1:0];
    if (add_clamp) add_sat = add_full[WIDTH] ? MINV : MAXV;
  end

  always_comb begin
    acc_next  = acc;
    flag_next = sat_flag;
    if (prod_valid) begin
      acc_next  = add_sat;
      flag_next = sat_flag | prod_sat | add_clamp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_sat   <= 1'b0;
      sat_flag   <= 1'b0;
      sum        <= '0;
      sum_sat    <= 1'b0;
      sum_valid  <= 1'b0;
    end else begin
      prod_valid <= accept;
      if (accept) begin
        prod     <= mul_sat;
        prod_sat <= mul_clamp;
      end
      acc      <= acc_next;
      sat_flag <= flag_next;
      case (state)
        IDLE: begin
          // No product is in flight in IDLE, so the bias load cannot collide with an add.
          if (accept) begin
            acc      <= bias;
            sat_flag <= 1'b0;
            state    <= in_last ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept && in_last) state <= DRAIN;
        end
        DRAIN: begin
          sum       <= acc_next;
          sum_sat   <= flag_next;
          sum_valid <= 1'b1;
          state     <= OUT;
        end
        default: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_data = '0;
  logic [47:0] in_weight = '0;
  logic        in_last = 1'b0;
  logic [47:0] bias = '0;
  logic        sum_valid;
  logic        sum_ready = 1'b1;
  logic [47:0] sum;
  logic        sum_sat;

  neuron_accumulator #(.WIDTH(48), .FRAC(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_last   (in_last),
    .bias      (bias),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum       (sum),
    .sum_sat   (sum_sat)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [48:0] exp_q[$];   // {sat, sum}
  logic [47:0] fdat[$];
  logic [47:0] fwt[$];
  logic [48:0] last_exp;
  bit          rand_ready = 1'b0;

  localparam logic signed [127:0] MAXV = (128'sd1 <<< 47) - 128'sd1;
  localparam logic signed [127:0] MINV = -(128'sd1 <<< 47);
  localparam logic [47:0] ONE = 48'h000001000000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic signed [127:0] sx(input logic [47:0] v);
    return {{80{v[47]}}, v};
  endfunction

  // Reference: real-valued arithmetic in a wide integer domain, clamped by comparison.
  function automatic logic signed [127:0] clamp(input logic signed [127:0] v, inout bit s);
    if (v > MAXV) begin s = 1'b1; return MAXV; end
    if (v < MINV) begin s = 1'b1; return MINV; end
    return v;
  endfunction

  function automatic logic [48:0] model(input logic [47:0] b);
    logic signed [127:0] acc, p;
    bit s;
    s   = 1'b0;
    acc = sx(b);
    for (int i = 0; i < fdat.size(); i++) begin
      p   = (sx(fdat[i]) * sx(fwt[i])) >>> 24;
      p   = clamp(p, s);
      acc = clamp(acc + p, s);
    end
    return {s, acc[47:0]};
  endfunction

  function automatic logic [47:0] rnd_val();
    logic [63:0] r;
    longint l;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) return r[47:0];
    l = longint'(int'($urandom_range(0, 16)) - 8) * 64'sd16777216 + longint'(r[23:0]);
    return l[47:0];
  endfunction

  task automatic beat(input logic [47:0] d, input logic [47:0] w, input logic l,
                      input logic [47:0] b);
    bit ok;
    in_valid = 1'b1; in_data = d; in_weight = w; in_last = l; bias = b;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout actual=no_accept required=accept at %0t", $time);
    end
    in_valid = 1'b0; in_last = 1'b0;
    bias = {$urandom, 16'h5a5a};   // later bias values must be ignored
  endtask

  // Drives the frame in fdat/fwt and pushes its model result; returns just after the last edge.
  task automatic run_frame(input logic [47:0] b, input int gapmax);
    last_exp = model(b);
    exp_q.push_back(last_exp);
    for (int i = 0; i < fdat.size(); i++) begin
      beat(fdat[i], fwt[i], i == fdat.size() - 1, (i == 0) ? b : bias);
      if (i != fdat.size() - 1 && gapmax > 0) begin
        repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
      end
    end
    fdat.delete(); fwt.delete();
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    @(negedge clk);
    while (!sum_valid && t < 50) begin @(negedge clk); t++; end
    check(nm, 64'(sum_valid), 64'd1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_sum actual=%h required=none at %0t", sum, $time);
      end else begin
        logic [48:0] e;
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e[47:0]));
        check("sum_sat", 64'(sum_sat), 64'(e[48]));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) sum_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_sum_valid", 64'(sum_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_sum_sat", 64'(sum_sat), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Two-beat frame and latency.
    fdat = '{ONE, 48'h000000800000}; fwt = '{48'h000002000000, 48'hFFFFFF000000};
    run_frame(48'h0, 0);
    check("model_frame1", 64'(last_exp), 64'h000001800000);
    @(negedge clk); check("lat_drain", 64'(sum_valid), 64'd0);
    @(negedge clk); check("lat_out", 64'(sum_valid), 64'd1);

    // Single beat.
    fdat = '{48'h000003000000}; fwt = '{48'hFFFFFE000000};
    run_frame(48'h000000400000, 0);
    check("model_single", 64'(last_exp), 64'h0FFFFFA400000);

    // Overflow then a clean frame.
    fdat = '{48'h7FFFFF000000}; fwt = '{48'h000002000000};
    run_frame(48'h0, 0);
    check("model_ovf", 64'(last_exp), 64'h17FFFFFFFFFFF);
    fdat = '{ONE}; fwt = '{ONE};
    run_frame(48'h0, 0);

    // Backpressure.
    wait_valid("pre_bp_drain");
    @(posedge clk); #1;
    sum_ready = 1'b0;
    fdat = '{ONE, ONE}; fwt = '{48'h000000400000, ONE};
    run_frame(48'h0, 0);
    wait_valid("bp_valid");
    in_valid = 1'b1; in_data = ONE; in_weight = ONE; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 64'(sum_valid), 64'd1);
      check("bp_hold_sum", 64'(sum), 64'(last_exp[47:0]));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    sum_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", 64'(sum_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Input gaps, bias -1.0.
    repeat (4) begin fdat.push_back(ONE); fwt.push_back(ONE); end
    run_frame(48'hFFFFFF000000, 3);
    check("model_gaps", 64'(last_exp), 64'h000003000000);
    wait_valid("gaps_valid");
    @(posedge clk); #1;

    // Reset mid-frame.
    beat(48'h000005000000, ONE, 1'b0, ONE);
    beat(48'h000005000000, ONE, 1'b0, ONE);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_sum_valid", 64'(sum_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fdat = '{ONE}; fwt = '{ONE};
    run_frame(48'h0, 0);

    // Randomized frames with random backpressure.
    @(posedge clk); #1;
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin fdat.push_back(rnd_val()); fwt.push_back(rnd_val()); end
      run_frame(rnd_val(), 2);
    end
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    rand_ready = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
